// File: rtl/dp_ctrl_pkg.sv
// Shared types and constants for the dp_ctrl_seq control unit.
// Optional trap on class 110 is enabled by DP_CTRL_ILLEGAL_TRAP_EN.
package dp_ctrl_pkg;

  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  localparam int CLS_HI = 15;
  localparam int CLS_LO = 13;
  localparam int OP_HI  = 12;
  localparam int OP_LO  = 9;
  localparam int RD_HI  = 8;
  localparam int RD_LO  = 6;
  localparam int RSA_HI = 5;
  localparam int RSA_LO = 3;
  localparam int RSB_HI = 2;
  localparam int RSB_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ALU_R = 3'd0,
    C_ALU_I = 3'd1,
    C_LD    = 3'd2,
    C_ST    = 3'd3,
    C_BRZ   = 3'd4,
    C_JMP   = 3'd5,
    C_RSVD  = 3'd6,
    C_HALT  = 3'd7
  } cls_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_BR,
    PC_JMP
  } pc_sel_t;

endpackage

// File: rtl/dp_ctrl_decode.sv
// Combinational decode of IR/state/zflag into datapath controls.
// Holds no state; the top owns PC, IR, zflag and the FSM.
module dp_ctrl_decode
  import dp_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH = 16
) (
  input  logic [BUS_WIDTH-1:0] ir,
  input  state_t               state,
  input  logic                 zflag,
  input  logic                 mem_ready,
  output cls_t                 cls,
  output logic                 regWrite,
  output logic [2:0]           rsA,
  output logic [2:0]           rsB,
  output logic [2:0]           rd,
  output logic [2:0]           constant_in,
  output logic                 MB,
  output logic                 MD,
  output logic [3:0]           op_select,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 addr_dp,
  output logic                 zf_load,
  output logic                 halted,
  output pc_sel_t              pc_sel
);

  logic is_alu;

  assign cls    = cls_t'(ir[CLS_HI:CLS_LO]);
  assign is_alu = (cls == C_ALU_R) || (cls == C_ALU_I);

  always_comb begin
    regWrite    = 1'b0;
    rsA         = '0;
    rsB         = '0;
    rd          = '0;
    constant_in = '0;
    MB          = 1'b0;
    MD          = 1'b0;
    op_select   = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_dp     = 1'b0;
    zf_load     = 1'b0;
    halted      = 1'b0;
    pc_sel      = PC_HOLD;
    if (state == S_EXEC || state == S_MEM) begin
      rsA         = ir[RSA_HI:RSA_LO];
      rsB         = ir[RSB_HI:RSB_LO];
      rd          = ir[RD_HI:RD_LO];
      constant_in = ir[RSB_HI:RSB_LO];
      op_select   = ir[OP_HI:OP_LO];
    end
    unique case (1'b1)
      state == S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) pc_sel = PC_INC;
      end
      state == S_EXEC: begin
        unique case (1'b1)
          is_alu: begin
            regWrite = 1'b1;
            MB       = (cls == C_ALU_I);
            zf_load  = 1'b1;
          end
          cls == C_BRZ: if (zflag) pc_sel = PC_BR;
          cls == C_JMP: pc_sel = PC_JMP;
          default: ;
        endcase
      end
      state == S_MEM: begin
        mem_req = 1'b1;
        addr_dp = 1'b1;
        mem_we  = (cls == C_ST);
        // LD write-back lands on the same edge the memory accepts
        if (cls == C_LD && mem_ready) begin
          regWrite = 1'b1;
          MD       = 1'b1;
        end
      end
      state == S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/dp_ctrl_seq.sv
// Multi-cycle control sequencer: PC, IR, zero flag and FSM.
// DP_CTRL_ILLEGAL_TRAP_EN: class 110 halts and sets sticky illegal.
module dp_ctrl_seq
  import dp_ctrl_pkg::*;
#(
  parameter int                   BUS_WIDTH = 16,
  parameter logic [BUS_WIDTH-1:0] RESET_PC  = BUS_WIDTH'(RESET_PC_DEF)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [BUS_WIDTH-1:0] mem_addr,
  input  logic                 mem_ready,
  input  logic [BUS_WIDTH-1:0] mem_rdata,
  input  logic [BUS_WIDTH-1:0] dp_addr,
  input  logic                 dp_zero,
  output logic                 regWrite,
  output logic [2:0]           rsA,
  output logic [2:0]           rsB,
  output logic [2:0]           rd,
  output logic [2:0]           constant_in,
  output logic                 MB,
  output logic                 MD,
  output logic [3:0]           op_select,
  output logic                 halted
`ifdef DP_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                 illegal
`endif
);

  state_t               state;
  state_t               state_nx;
  logic [BUS_WIDTH-1:0] pc;
  logic [BUS_WIDTH-1:0] ir;
  logic                 zflag;
  cls_t                 cls;
  logic                 addr_dp;
  logic                 zf_load;
  pc_sel_t              pc_sel;
  logic [BUS_WIDTH-1:0] br_off;

  dp_ctrl_decode #(.BUS_WIDTH(BUS_WIDTH)) u_dec (
    .ir          (ir),
    .state       (state),
    .zflag       (zflag),
    .mem_ready   (mem_ready),
    .cls         (cls),
    .regWrite    (regWrite),
    .rsA         (rsA),
    .rsB         (rsB),
    .rd          (rd),
    .constant_in (constant_in),
    .MB          (MB),
    .MD          (MD),
    .op_select   (op_select),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .addr_dp     (addr_dp),
    .zf_load     (zf_load),
    .halted      (halted),
    .pc_sel      (pc_sel)
  );

  // 6-bit signed branch offset split across the rd and rsB fields
  assign br_off = {{(BUS_WIDTH-6){ir[RD_HI]}},
                   ir[RD_HI:RD_LO], ir[RSB_HI:RSB_LO]};

  assign mem_addr = addr_dp ? dp_addr :
                    mem_req ? pc : '0;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  state_nx = S_FETCH;
      S_FETCH: if (mem_ready) state_nx = S_EXEC;
      S_EXEC: begin
        unique case (cls)
          C_LD, C_ST: state_nx = S_MEM;
          C_HALT:     state_nx = S_HALT;
`ifdef DP_CTRL_ILLEGAL_TRAP_EN
          C_RSVD:     state_nx = S_HALT;
`endif
          default:    state_nx = S_FETCH;
        endcase
      end
      S_MEM:   if (mem_ready) state_nx = S_FETCH;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      ir    <= '0;
      zflag <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH && mem_ready) ir <= mem_rdata;
      unique case (pc_sel)
        PC_INC:  pc <= pc + BUS_WIDTH'(1);
        PC_BR:   pc <= pc + br_off;
        PC_JMP:  pc <= dp_addr;
        default: ;
      endcase
      if (zf_load) zflag <= dp_zero;
    end
  end

`ifdef DP_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal <= 1'b0;
    else if (state == S_EXEC && cls == C_RSVD) illegal <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_dp_ctrl_seq.sv
// Directed self-checking bench for dp_ctrl_seq.
// Walks a fixed program through fetch, ALU, LD, BRZ, JMP, HALT, ST.
module tb_dp_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic [15:0] dp_addr;
  logic        dp_zero;
  logic        regWrite;
  logic [2:0]  rsA;
  logic [2:0]  rsB;
  logic [2:0]  rd;
  logic [2:0]  constant_in;
  logic        MB;
  logic        MD;
  logic [3:0]  op_select;
  logic        halted;
`ifdef DP_CTRL_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int checks = 0;
  int errors = 0;

  dp_ctrl_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .dp_addr     (dp_addr),
    .dp_zero     (dp_zero),
    .regWrite    (regWrite),
    .rsA         (rsA),
    .rsB         (rsB),
    .rd          (rd),
    .constant_in (constant_in),
    .MB          (MB),
    .MD          (MD),
    .op_select   (op_select),
    .halted      (halted)
`ifdef DP_CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal     (illegal)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input logic [2:0] c,
                                      input logic [3:0] op,
                                      input logic [2:0] d,
                                      input logic [2:0] a,
                                      input logic [2:0] b);
    return {c, op, d, a, b};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; mem_ready = 1'b1;
    mem_rdata = '0; dp_addr = '0; dp_zero = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({mem_req, mem_we, regWrite, MB, MD, halted, mem_addr, rd, rsA}
        !== 28'h0) begin
      errors++;
      $display("FAIL reset_outs: req=%b addr=%h halted=%b want all 0",
               mem_req, mem_addr, halted);
    end
    rst_n = 1'b1; #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_req: got %b want 0", mem_req);
    end
    @(negedge clk);
  endtask

  task automatic test_alu_i;
    mem_rdata = enc(3'b001, 4'b0010, 3'd3, 3'd1, 3'd5);
    mem_ready = 1'b1; #1;
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 16'h0000}) begin
      errors++;
      $display("FAIL fetch0: req=%b we=%b addr=%h want 1 0 0000",
               mem_req, mem_we, mem_addr);
    end
    @(negedge clk);
    mem_ready = 1'b0; dp_zero = 1'b0; #1;
    checks++;
    if ({regWrite, MB, MD, constant_in, rd, rsA, op_select, mem_req}
        !== {3'b110, 3'd5, 3'd3, 3'd1, 4'b0010, 1'b0}) begin
      errors++;
      $display("FAIL alu_i_exec: wr=%b mb=%b md=%b k=%0d rd=%0d a=%0d op=%h",
               regWrite, MB, MD, constant_in, rd, rsA, op_select);
    end
    @(negedge clk); #1;
    checks++;
    if ({regWrite, mem_req, mem_addr} !== {2'b01, 16'h0001}) begin
      errors++;
      $display("FAIL alu_i_after: wr=%b req=%b addr=%h want 0 1 0001",
               regWrite, mem_req, mem_addr);
    end
  endtask

  task automatic test_ld;
    mem_rdata = enc(3'b010, 4'b0000, 3'd2, 3'd4, 3'd0);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; dp_addr = 16'h0040; #1;
    checks++;
    if ({mem_req, regWrite} !== 2'b00) begin
      errors++;
      $display("FAIL ld_exec: req=%b wr=%b want 0 0", mem_req, regWrite);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3); #1;
      checks++;
      if ({mem_req, mem_we, mem_addr, regWrite, MD, rd}
          !== {2'b10, 16'h0040, (i == 3), (i == 3), 3'd2}) begin
        errors++;
        $display("FAIL ld_mem%0d: req=%b we=%b addr=%h wr=%b md=%b rd=%0d",
                 i, mem_req, mem_we, mem_addr, regWrite, MD, rd);
      end
      @(negedge clk);
    end
    mem_ready = 1'b0; #1;
    checks++;
    if ({regWrite, mem_req, mem_addr} !== {2'b01, 16'h0002}) begin
      errors++;
      $display("FAIL ld_after: wr=%b req=%b addr=%h want 0 1 0002",
               regWrite, mem_req, mem_addr);
    end
  endtask

  task automatic test_branch;
    mem_rdata = enc(3'b000, 4'b0001, 3'd1, 3'd2, 3'd3);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; dp_zero = 1'b1; #1;
    checks++;
    if ({regWrite, MB, rsB} !== {2'b10, 3'd3}) begin
      errors++;
      $display("FAIL alu_r_exec: wr=%b mb=%b b=%0d want 1 0 3",
               regWrite, MB, rsB);
    end
    @(negedge clk);
    mem_rdata = enc(3'b101, 4'b0000, 3'd0, 3'd0, 3'd0);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; dp_addr = 16'h0010; dp_zero = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (mem_addr !== 16'h0010) begin
      errors++;
      $display("FAIL jmp_target: got %h want 0010", mem_addr);
    end
    mem_rdata = enc(3'b100, 4'b0000, 3'b111, 3'd0, 3'b110);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (mem_addr !== 16'h000F) begin
      errors++;
      $display("FAIL brz_taken: got %h want 000f", mem_addr);
    end
    mem_rdata = enc(3'b000, 4'b0011, 3'd4, 3'd5, 3'd6);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; dp_zero = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (mem_addr !== 16'h0010) begin
      errors++;
      $display("FAIL alu_to_10: got %h want 0010", mem_addr);
    end
    mem_rdata = enc(3'b100, 4'b0000, 3'b111, 3'd0, 3'b110);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; dp_zero = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (mem_addr !== 16'h0011) begin
      errors++;
      $display("FAIL brz_not_taken: got %h want 0011", mem_addr);
    end
  endtask

  task automatic test_wrap;
    mem_rdata = enc(3'b101, 4'b0000, 3'd0, 3'd7, 3'd0);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; dp_addr = 16'hFFFF;
    @(negedge clk); #1;
    checks++;
    if (mem_addr !== 16'hFFFF) begin
      errors++;
      $display("FAIL jmp_ffff: got %h want ffff", mem_addr);
    end
    mem_rdata = enc(3'b000, 4'b0000, 3'd1, 3'd1, 3'd1);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; dp_zero = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL pc_wrap: req=%b addr=%h want 1 0000",
               mem_req, mem_addr);
    end
  endtask

  task automatic test_halt;
    mem_rdata = enc(3'b111, 4'b0000, 3'd0, 3'd0, 3'd0);
    mem_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({halted, mem_req} !== 2'b00) begin
      errors++;
      $display("FAIL halt_exec: halted=%b req=%b want 0 0", halted, mem_req);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({halted, mem_req, regWrite, mem_addr, rsA}
          !== {3'b100, 16'h0000, 3'd0}) begin
        errors++;
        $display("FAIL halt_hold%0d: halted=%b req=%b wr=%b addr=%h",
                 i, halted, mem_req, regWrite, mem_addr);
      end
    end
  endtask

  task automatic test_st_reset;
    rst_n = 1'b0; #1;
    checks++;
    if ({halted, mem_req} !== 2'b00) begin
      errors++;
      $display("FAIL halt_reset: halted=%b req=%b want 0 0", halted, mem_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rdata = enc(3'b011, 4'b0000, 3'd0, 3'd5, 3'd6);
    mem_ready = 1'b1; #1;
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL refetch0: req=%b addr=%h want 1 0000", mem_req, mem_addr);
    end
    @(negedge clk);
    mem_ready = 1'b0; dp_addr = 16'h1234;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({mem_req, mem_we, regWrite, mem_addr} !== {3'b110, 16'h1234}) begin
        errors++;
        $display("FAIL st_wait%0d: req=%b we=%b wr=%b addr=%h", i,
                 mem_req, mem_we, regWrite, mem_addr);
      end
      if (i == 0) @(negedge clk);
    end
    rst_n = 1'b0; #1;
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {2'b00, 16'h0000}) begin
      errors++;
      $display("FAIL st_abort: req=%b we=%b addr=%h want 0 0 0000",
               mem_req, mem_we, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1; #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL st_idle: got %b want 0", mem_req);
    end
    @(negedge clk);
  endtask

  task automatic test_reserved;
    mem_rdata = enc(3'b110, 4'hA, 3'd1, 3'd2, 3'd3);
    mem_ready = 1'b1; #1;
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL restart_pc: req=%b addr=%h want 1 0000",
               mem_req, mem_addr);
    end
    @(negedge clk);
    mem_ready = 1'b0; #1;
    checks++;
    if ({regWrite, mem_req} !== 2'b00) begin
      errors++;
      $display("FAIL rsvd_exec: wr=%b req=%b want 0 0", regWrite, mem_req);
    end
    @(negedge clk); #1;
    checks++;
`ifdef DP_CTRL_ILLEGAL_TRAP_EN
    if ({halted, illegal, mem_req} !== 3'b110) begin
      errors++;
      $display("FAIL rsvd_trap: halted=%b illegal=%b req=%b want 1 1 0",
               halted, illegal, mem_req);
    end
`else
    if ({halted, mem_req, mem_addr} !== {2'b01, 16'h0001}) begin
      errors++;
      $display("FAIL rsvd_nop: halted=%b req=%b addr=%h want 0 1 0001",
               halted, mem_req, mem_addr);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_alu_i;
    test_ld;
    test_branch;
    test_wrap;
    test_halt;
    test_st_reset;
    test_reserved;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
